// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : owner of the memory port in the previous cycle
//                 (IDLE, CPU, EXT, EXT_LOCK)
//   port_id_t   : requester identity, used for round-robin bookkeeping
//   DMEM_ARB_AW / DMEM_ARB_DW : default word-address and data widths
//   next_owner  : maps this cycle's grants to the next FSM state
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int DMEM_ARB_AW = 6;
   localparam int DMEM_ARB_DW = 32;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU      = 2'd1,
      EXT      = 2'd2,
      EXT_LOCK = 2'd3
   } arb_state_t;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_EXT = 1'b1
   } port_id_t;

   // The state remembers who owned the port last cycle, and whether the
   // external owner asked to keep it.
   function automatic arb_state_t next_owner(input logic cpu_gnt,
                                             input logic ext_gnt,
                                             input logic ext_lock);
      arb_state_t nxt;
      nxt = IDLE;
      if (ext_gnt) begin
         nxt = ext_lock ? EXT_LOCK : EXT;
      end else if (cpu_gnt) begin
         nxt = CPU;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/dmem_arb_resp.sv
// ---------------------------------------------------------------------------
// dmem_arb_resp
// Per-port read response register. A read granted in one cycle returns its
// data one cycle later with rvalid high; rdata holds its last value otherwise.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset (clears rvalid and rdata)
//   capture : a read for this port is granted this cycle
//   mem_rd  : combinational read data from the memory
//   rvalid  : read response valid (one cycle after the grant)
//   rdata   : registered read data
// ---------------------------------------------------------------------------
module dmem_arb_resp #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          capture,
   input  logic [DW-1:0] mem_rd,
   output logic          rvalid,
   output logic [DW-1:0] rdata
);

   // Because the reset is asynchronous, a read granted in the cycle where
   // reset asserts is simply lost: the flops are held clear at the edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= capture;
         if (capture) begin
            rdata <= mem_rd;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates a single-port data memory between the CPU data side and an
// external (loader/debug) master. Grants are combinational; read data comes
// back one cycle after the grant. The external master may lock the port, but
// a waiting CPU is let in after BURST_MAX consecutive locked grants.
//
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie-breaking
// outside a lock; otherwise the CPU always wins ties.
//
// Parameters:
//   AW        : data-memory word-address width
//   DW        : data width
//   BURST_MAX : locked external grants allowed while the CPU waits (1..15)
// Ports:
//   clk, rst                       : clock and async active-low reset
//   cpu_req/we/addr/wdata          : CPU access request
//   cpu_gnt, cpu_rvalid, cpu_rdata : CPU grant and read response
//   ext_req/we/addr/wdata/lock     : external access request, lock hint
//   ext_gnt, ext_rvalid, ext_rdata : external grant and read response
//   mem_we, mem_a, mem_wd, mem_rd  : memory port (mem_rd combinational)
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = DMEM_ARB_AW,
   parameter int DW        = DMEM_ARB_DW,
   parameter int BURST_MAX = 4
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,

   input  logic          ext_req,
   input  logic          ext_we,
   input  logic [AW-1:0] ext_addr,
   input  logic [DW-1:0] ext_wdata,
   input  logic          ext_lock,
   output logic          ext_gnt,
   output logic          ext_rvalid,
   output logic [DW-1:0] ext_rdata,

   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd
);

   // Four bits cover the whole legal BURST_MAX range.
   localparam int            CW          = 4;
   localparam logic [CW-1:0] BURST_LIMIT = CW'(BURST_MAX);

   arb_state_t    state;
   logic [CW-1:0] burst_cnt;
   logic          lock_hold;
   logic          cap_hit;
   logic          tie_ext;

`ifdef DMEM_ARB_RR_EN
   port_id_t      last_winner;

   // Round-robin: on a tie the port that did not win last time goes first.
   always_comb begin
      tie_ext = (last_winner == PORT_CPU);
   end
`else
   // Fixed priority: the CPU wins every tie outside a lock.
   always_comb begin
      tie_ext = 1'b0;
   end
`endif

   // Grant decision. A single requester always gets the port. With both
   // requesting, a held lock keeps the external master in until the burst
   // cap is reached, at which point the CPU is forced in; otherwise the
   // tie-break decides.
   always_comb begin
      cpu_gnt   = 1'b0;
      ext_gnt   = 1'b0;
      cap_hit   = (burst_cnt >= BURST_LIMIT);
      lock_hold = (state == EXT_LOCK) && ext_lock && !cap_hit;
      case ({cpu_req, ext_req})
         2'b10: cpu_gnt = 1'b1;
         2'b01: ext_gnt = 1'b1;
         2'b11: begin
            if (lock_hold) begin
               ext_gnt = 1'b1;
            end else if (cap_hit) begin
               cpu_gnt = 1'b1;
            end else if (tie_ext) begin
               ext_gnt = 1'b1;
            end else begin
               cpu_gnt = 1'b1;
            end
         end
         default: begin
            cpu_gnt = 1'b0;
            ext_gnt = 1'b0;
         end
      endcase
   end

   // Memory port mux. An idle port drives zeros, and writes are suppressed
   // while reset is asserted even though grants still follow the requests.
   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      if (cpu_gnt) begin
         mem_we = cpu_we & rst;
         mem_a  = cpu_addr;
         mem_wd = cpu_wdata;
      end else if (ext_gnt) begin
         mem_we = ext_we & rst;
         mem_a  = ext_addr;
         mem_wd = ext_wdata;
      end
   end

   // Owner FSM and burst counter. The counter only advances on locked
   // external grants that keep a requesting CPU waiting, saturates at the
   // cap, and clears as soon as the CPU gets in or the lock is released.
   // Reset drops any lock so arbitration restarts from IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         burst_cnt <= '0;
`ifdef DMEM_ARB_RR_EN
         last_winner <= PORT_EXT;
`endif
      end else begin
         state <= next_owner(cpu_gnt, ext_gnt, ext_lock);
         if (cpu_gnt || !ext_lock) begin
            burst_cnt <= '0;
         end else if (ext_gnt && cpu_req && (burst_cnt < BURST_LIMIT)) begin
            burst_cnt <= burst_cnt + CW'(1);
         end
`ifdef DMEM_ARB_RR_EN
         if (cpu_req && ext_req && (cpu_gnt || ext_gnt)) begin
            last_winner <= cpu_gnt ? PORT_CPU : PORT_EXT;
         end
`endif
      end
   end

   // One response register per port; each captures only its own reads.
   dmem_arb_resp #(
      .DW (DW)
   ) u_cpu_resp (
      .clk     (clk),
      .rst     (rst),
      .capture (cpu_gnt & ~cpu_we),
      .mem_rd  (mem_rd),
      .rvalid  (cpu_rvalid),
      .rdata   (cpu_rdata)
   );

   dmem_arb_resp #(
      .DW (DW)
   ) u_ext_resp (
      .clk     (clk),
      .rst     (rst),
      .capture (ext_gnt & ~ext_we),
      .mem_rd  (mem_rd),
      .rvalid  (ext_rvalid),
      .rdata   (ext_rdata)
   );

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A behavioural model tracks the
// previous owner, the lock burst count, a shadow copy of memory and the
// expected read responses; every cycle the DUT outputs are compared to it.
// Directed scenarios cover reset, simultaneous writes, the lock cap, lock
// release and reset during a locked read; then random traffic follows.
// Honours DMEM_ARB_RR_EN in the model when the macro is defined.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int BM = 4;

   localparam int OWN_IDLE = 0;
   localparam int OWN_CPU  = 1;
   localparam int OWN_EXT  = 2;
   localparam int OWN_LOCK = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_gnt;
   logic          cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          ext_req = 1'b0;
   logic          ext_we = 1'b0;
   logic [AW-1:0] ext_addr = '0;
   logic [DW-1:0] ext_wdata = '0;
   logic          ext_lock = 1'b0;
   logic          ext_gnt;
   logic          ext_rvalid;
   logic [DW-1:0] ext_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;
   logic [DW-1:0] mem_rd;

   int checkCount = 0;
   int errorCount = 0;

   // Behavioural model state
   int            mOwner;
   int            mBurst;
   bit            mRvCpu;
   bit            mRvExt;
   logic [DW-1:0] mRdCpu;
   logic [DW-1:0] mRdExt;
   logic [DW-1:0] mMem [0:63];
   bit            mLastExt;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .AW        (AW),
      .DW        (DW),
      .BURST_MAX (BM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata),
      .ext_lock   (ext_lock),
      .ext_gnt    (ext_gnt),
      .ext_rvalid (ext_rvalid),
      .ext_rdata  (ext_rdata),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   function automatic logic [DW-1:0] initWord(input int i);
      return (i == 5) ? 32'h0000_1234 : (32'hC0DE_0000 + 32'(i) * 32'h0000_0101);
   endfunction

   // Memory device driven by the DUT; contents are loaded on the first
   // clock edge, which always falls inside the initial reset.
   logic [DW-1:0] mem [0:63];
   bit memReady = 1'b0;

   always @(posedge clk) begin
      if (!memReady) begin
         for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
         memReady <= 1'b1;
      end else if (mem_we) begin
         mem[mem_a] <= mem_wd;
      end
   end

   assign mem_rd = mem[mem_a];

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic modelReset();
      mOwner   = OWN_IDLE;
      mBurst   = 0;
      mRvCpu   = 1'b0;
      mRvExt   = 1'b0;
      mRdCpu   = '0;
      mRdExt   = '0;
      mLastExt = 1'b1;
   endtask

   // Who should own the port this cycle, from the arbitration rules.
   task automatic predictGrant(output bit gc, output bit ge);
      gc = 1'b0;
      ge = 1'b0;
      if (cpu_req && !ext_req) gc = 1'b1;
      else if (ext_req && !cpu_req) ge = 1'b1;
      else if (cpu_req && ext_req) begin
         if (mOwner == OWN_LOCK && ext_lock && mBurst < BM) ge = 1'b1;
         else if (mBurst >= BM) gc = 1'b1;
         else begin
`ifdef DMEM_ARB_RR_EN
            gc = mLastExt;
            ge = !mLastExt;
`else
            gc = 1'b1;
`endif
         end
      end
   endtask

   // Advance the model across a rising edge using the inputs held there.
   task automatic modelAdvance();
      bit gc, ge;
      if (!rst) begin
         modelReset();
      end else begin
         predictGrant(gc, ge);
         mRvCpu = gc && !cpu_we;
         mRvExt = ge && !ext_we;
         if (mRvCpu) mRdCpu = mMem[cpu_addr];
         if (mRvExt) mRdExt = mMem[ext_addr];
         if (gc && cpu_we) mMem[cpu_addr] = cpu_wdata;
         if (ge && ext_we) mMem[ext_addr] = ext_wdata;
         if (gc || !ext_lock) mBurst = 0;
         else if (ge && cpu_req && mBurst < BM) mBurst = mBurst + 1;
         if (cpu_req && ext_req && (gc || ge)) mLastExt = ge;
         if (ge) mOwner = ext_lock ? OWN_LOCK : OWN_EXT;
         else if (gc) mOwner = OWN_CPU;
         else mOwner = OWN_IDLE;
      end
   endtask

   // One cycle: let the model see the previous edge, drive new inputs on
   // the falling edge, then compare every output a little later.
   task automatic applyStimulus(input bit cr, input bit cw, input logic [AW-1:0] ca,
                                input logic [DW-1:0] cwd, input bit er, input bit ew,
                                input logic [AW-1:0] ea, input logic [DW-1:0] ewd,
                                input bit el, input bit rstVal);
      bit gc, ge;
      logic [AW-1:0] expA;
      logic [DW-1:0] expWd;
      @(posedge clk);
      modelAdvance();
      @(negedge clk);
      cpu_req = cr;  cpu_we = cw;  cpu_addr = ca;  cpu_wdata = cwd;
      ext_req = er;  ext_we = ew;  ext_addr = ea;  ext_wdata = ewd;
      ext_lock = el; rst = rstVal;
      if (!rst) modelReset();
      #2;
      predictGrant(gc, ge);
      expA  = gc ? ca  : (ge ? ea  : '0);
      expWd = gc ? cwd : (ge ? ewd : '0);
      checkOutput("gnt_exclusive", 64'(cpu_gnt & ext_gnt), 64'(0));
      checkOutput("cpu_gnt", 64'(cpu_gnt), 64'(gc));
      checkOutput("ext_gnt", 64'(ext_gnt), 64'(ge));
      checkOutput("mem_we", 64'(mem_we), 64'(((gc && cw) || (ge && ew)) && rstVal));
      checkOutput("mem_a", 64'(mem_a), 64'(expA));
      checkOutput("mem_wd", 64'(mem_wd), 64'(expWd));
      checkOutput("cpu_rvalid", 64'(cpu_rvalid), 64'(mRvCpu));
      checkOutput("ext_rvalid", 64'(ext_rvalid), 64'(mRvExt));
      checkOutput("cpu_rdata", 64'(cpu_rdata), 64'(mRdCpu));
      checkOutput("ext_rdata", 64'(ext_rdata), 64'(mRdExt));
   endtask

   task automatic idleCycle(input bit rstVal);
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0, rstVal);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mMem[i] = initWord(i);
      modelReset();

      // Reset with both masters requesting
      applyStimulus(1, 0, 6'd5, '0, 1, 0, 6'd7, '0, 0, 0);
      checkOutput("rst_cpu_gnt", 64'(cpu_gnt), 64'(1));
      checkOutput("rst_cpu_rvalid", 64'(cpu_rvalid), 64'(0));
      checkOutput("rst_ext_rvalid", 64'(ext_rvalid), 64'(0));
      applyStimulus(1, 1, 6'd5, 32'hDEAD, 1, 1, 6'd7, 32'hBEEF, 0, 0);
      checkOutput("rst_mem_we", 64'(mem_we), 64'(0));
      checkOutput("rst_cpu_rvalid2", 64'(cpu_rvalid), 64'(0));
      idleCycle(1);
      applyStimulus(1, 0, 6'd5, '0, 0, 0, '0, '0, 0, 1);
      checkOutput("rd5_cpu_gnt", 64'(cpu_gnt), 64'(1));
      idleCycle(1);
      checkOutput("rd5_cpu_rvalid", 64'(cpu_rvalid), 64'(1));
      checkOutput("rd5_cpu_rdata", 64'(cpu_rdata), 64'(32'h1234));

      // Simultaneous writes
      applyStimulus(1, 1, 6'd1, 32'hA, 1, 1, 6'd2, 32'hB, 0, 1);
      checkOutput("sw_cpu_first", 64'(cpu_gnt), 64'(1));
      checkOutput("sw_ext_stall", 64'(ext_gnt), 64'(0));
`ifdef DMEM_ARB_RR_EN
      applyStimulus(1, 1, 6'd1, 32'hA, 1, 1, 6'd2, 32'hB, 0, 1);
      checkOutput("sw_rr_ext_next", 64'(ext_gnt), 64'(1));
      checkOutput("sw_rr_cpu_wait", 64'(cpu_gnt), 64'(0));
`else
      applyStimulus(0, 0, '0, '0, 1, 1, 6'd2, 32'hB, 0, 1);
      checkOutput("sw_ext_next", 64'(ext_gnt), 64'(1));
`endif
      applyStimulus(1, 0, 6'd1, '0, 0, 0, '0, '0, 0, 1);
      applyStimulus(0, 0, '0, '0, 1, 0, 6'd2, '0, 0, 1);
      checkOutput("sw_rd1", 64'(cpu_rdata), 64'(32'hA));
      idleCycle(1);
      checkOutput("sw_rd2", 64'(ext_rdata), 64'(32'hB));

      // Lock cap: lock established, then the CPU starts waiting at cycle 0
      applyStimulus(0, 0, '0, '0, 1, 0, 6'd10, '0, 1, 1);
      for (int c = 0; c <= BM; c++) begin
         applyStimulus(1, 0, 6'd3, '0, 1, 0, AW'(10 + c), '0, 1, 1);
         checkOutput($sformatf("cap_ext_c%0d", c), 64'(ext_gnt), 64'(c < BM));
         checkOutput($sformatf("cap_cpu_c%0d", c), 64'(cpu_gnt), 64'(c >= BM));
      end

      // Lock release: ext drops its request while locked
      applyStimulus(0, 0, '0, '0, 1, 1, 6'd20, 32'h55, 1, 1);
      applyStimulus(1, 0, 6'd20, '0, 0, 0, '0, '0, 1, 1);
      checkOutput("rel_cpu_gnt", 64'(cpu_gnt), 64'(1));
      checkOutput("rel_ext_gnt", 64'(ext_gnt), 64'(0));

      // Reset during a granted, locked external read
      applyStimulus(0, 0, '0, '0, 1, 0, 6'd9, '0, 1, 1);
      checkOutput("mr_ext_gnt", 64'(ext_gnt), 64'(1));
      #1 rst = 1'b0;
      idleCycle(0);
      checkOutput("mr_ext_rvalid", 64'(ext_rvalid), 64'(0));
      applyStimulus(1, 0, 6'd4, '0, 1, 0, 6'd9, '0, 1, 1);
      checkOutput("mr_idle_cpu_gnt", 64'(cpu_gnt), 64'(1));
      checkOutput("mr_idle_ext_gnt", 64'(ext_gnt), 64'(0));

      // Random traffic, lock asserted most of the time
      for (int n = 0; n < 1000; n++) begin
         applyStimulus(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                       AW'($urandom_range(0, 63)), DW'($urandom),
                       bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                       AW'($urandom_range(0, 63)), DW'($urandom),
                       ($urandom_range(0, 3) != 0), 1);
      end
      idleCycle(1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 6, meaning data-memory word-address width.
REQ-002 Parameter DW, default 32, meaning data width.
REQ-003 Parameter BURST_MAX, default 4, meaning the maximum number of consecutive locked external grants while the CPU is waiting; legal range 1..15.
REQ-004 The clock port SHALL be `clk  in  1`, the single clock; every state element updates on its rising edge.
REQ-005 The reset port SHALL be `rst  in  1`: asynchronous, active-low.
REQ-006 The CPU request port SHALL be `cpu_req  in  1`, meaning the CPU data-side access request.
REQ-007 `cpu_we in 1`, `cpu_addr in AW`, `cpu_wdata in DW`: CPU access type, address and write data.
REQ-008 `cpu_gnt out 1`: the CPU access is performed this cycle; when this is low with `cpu_req` high, the CPU is stalled.
REQ-009 `cpu_rvalid out 1`, `cpu_rdata out DW`: CPU read response.
REQ-010 `ext_req in 1`, `ext_we in 1`, `ext_addr in AW`, `ext_wdata in DW`, `ext_lock in 1`: external (loader/debug) request; `ext_lock` asks the arbiter to hold ownership.
REQ-011 `ext_gnt out 1`, `ext_rvalid out 1`, `ext_rdata out DW`: external grant and read response.
REQ-012 `mem_we out 1`, `mem_a out AW`, `mem_wd out DW`, `mem_rd in DW`: single data-memory port; `mem_rd` is combinational from `mem_a`.

Function
REQ-013 The arbiter SHALL assert at most one of `cpu_gnt` and `ext_gnt` in any cycle, and SHALL assert a grant only when the corresponding request is high.
REQ-014 Grant SHALL be combinational within the cycle; `mem_a`, `mem_wd` and `mem_we` come from the granted port, and `mem_we` = granted port's `we`.
REQ-015 With no grant, `mem_we` SHALL be 0 and `mem_a`/`mem_wd` SHALL be 0.
REQ-016 A granted read SHALL produce `rvalid`=1 on the same port exactly one cycle later, with `rdata` registered from `mem_rd`; `rdata` holds its value otherwise.
REQ-017 A granted write SHALL complete in the grant cycle, with no `rvalid`.
REQ-018 The FSM SHALL have states IDLE, CPU, EXT and EXT_LOCK, where the state records the owner of the previous cycle.
REQ-019 Any state with a single requester SHALL grant that requester.
REQ-020 In EXT_LOCK, if `ext_req`=1, `ext_lock`=1 and burst_cnt<BURST_MAX, EXT SHALL win even when `cpu_req`=1.
REQ-021 `burst_cnt` SHALL increment per locked ext grant while `cpu_req`=1, and clear on any CPU grant or when `ext_lock`=0.
REQ-022 When burst_cnt reaches BURST_MAX with `cpu_req`=1, the CPU SHALL be granted next and the counter SHALL clear.
REQ-023 The next state SHALL be EXT_LOCK when ext is granted with `ext_lock`=1, EXT when ext is granted otherwise, CPU when the CPU is granted, and IDLE when there is no grant.
REQ-024 If `ext_req` drops in EXT_LOCK, the lock SHALL release immediately; an unrequested grant SHALL never be given.

Reset
REQ-025 While `rst`=0, the arbiter SHALL hold state IDLE, burst_cnt=0, last_winner=EXT, both rvalid=0 and both rdata=0.
REQ-026 Grants SHALL follow REQ-013/REQ-019 combinationally even during reset, except that `mem_we` SHALL be forced to 0.
REQ-027 A read granted in the cycle reset asserts SHALL produce no rvalid.
REQ-028 Reset asserted mid-lock SHALL drop the lock, so that the first arbitration after reset release starts from IDLE.

Configuration
REQ-029 With `DMEM_ARB_RR_EN` defined, tie-breaking outside EXT_LOCK SHALL be round-robin: the port not equal to last_winner wins, and last_winner updates on every contested grant.
REQ-030 Without `DMEM_ARB_RR_EN`, the CPU SHALL always win ties outside EXT_LOCK, and last_winner SHALL not be implemented.
REQ-031 The burst cap SHALL be active in both builds.

Structure
REQ-032 Package dmem_arb_pkg SHALL hold the state enum (IDLE, CPU, EXT, EXT_LOCK), the port-id enum (PORT_CPU, PORT_EXT) and the default AW/DW constants.
REQ-033 The design SHALL contain one sub-module, dmem_arb_resp: the per-port rvalid/rdata response register.
REQ-034 dmem_arb_resp SHALL be instantiated twice.

Verification
REQ-035 Reset scenario: drive `rst`=0 with both requesters high; check both rvalid=0 and `mem_we`=0. Release reset, then drive cpu read addr 5 with mem[5]=0x1234; check `cpu_gnt`=1 and, next cycle, `cpu_rvalid`=1 with `cpu_rdata`=0x1234.
REQ-036 Simultaneous-write scenario: cpu write 0xA to addr 1 and ext write 0xB to addr 2 in the same cycle. Without the macro, check cpu granted with ext stalled, then ext granted next cycle. With the macro, check the grant order alternates on repeat.
REQ-037 Lock-cap scenario: with BURST_MAX=4, ext_lock=1 and ext_req held high, raise cpu_req at cycle 0; check ext granted in cycles 0-3 and cpu granted in cycle 4.
REQ-038 Lock-release scenario: drop ext_req during EXT_LOCK with cpu_req=1; check cpu granted in that same cycle.
REQ-039 Mid-operation reset scenario: assert rst during a granted ext read; check ext_rvalid stays 0 and the FSM is in IDLE after release.
REQ-040 Random scenario: across 1000 cycles of random requests, check cpu_gnt&ext_gnt is never 1, and each rvalid equals the registered previous-cycle granted read.
